// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, ALU-op codes,
// FSM states, memory access sizes and small opcode classifiers.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int ALU_ADD   = 0;
  localparam int ALU_SUB   = 1;
  localparam int ALU_RTYPE = 2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_IEXEC  = 4'd8,  S_IWB    = 4'd9,  S_BRANCH = 4'd10, S_JUMP  = 4'd11,
    S_ERROR  = 4'd12
  } state_t;

  // {unsigned, size}
  localparam logic [2:0] MSZ_BYTE   = 3'b000;
  localparam logic [2:0] MSZ_HALF   = 3'b001;
  localparam logic [2:0] MSZ_WORD   = 3'b010;
  localparam logic [2:0] MSZ_BYTE_U = 3'b100;
  localparam logic [2:0] MSZ_HALF_U = 3'b101;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_imm(input logic [5:0] op);
    return op inside {OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI};
  endfunction

  function automatic logic is_known(input logic [5:0] op);
    return is_load(op) || is_store(op) || is_imm(op) ||
           (op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_J});
  endfunction

  function automatic logic [2:0] mem_size_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_SB: return MSZ_BYTE;
      OP_LH, OP_SH: return MSZ_HALF;
      OP_LBU:       return MSZ_BYTE_U;
      OP_LHU:       return MSZ_HALF_U;
      default:      return MSZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_out_decode.sv
// Moore output decode for the multi-cycle control FSM: state and latched opcode
// to datapath controls, with a few strobes qualified by the memory ready signal.
module mips_mc_out_decode
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 6
) (
  input  logic               nrst,
  input  state_t             state,
  input  logic [5:0]         op_q,
  input  logic [5:0]         opcode,
  input  logic               ready,
  output logic               pc_write,
  output logic [1:0]         pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic [2:0]         mem_size,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_retired,
  output logic               illegal_op
);

  always_comb begin
    // NOTE: every output gets its idle value first so no path through the case infers a latch.
    pc_write      = 1'b0;
    pc_write_cond = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_size      = MSZ_WORD;
    ir_write      = 1'b0;
    reg_dst       = 1'b1;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = ALUOP_W'(ALU_RTYPE);
    pc_source     = 2'b00;
    instr_retired = 1'b0;
    illegal_op    = 1'b0;

    // Reset forces idle immediately, so a half-done access never strobes memory or the RF.
    if (nrst) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = ALUOP_W'(ALU_ADD);
          ir_write  = ready;
          pc_write  = ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          alu_op     = ALUOP_W'(ALU_ADD);
          illegal_op = !is_known(opcode);
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = ALUOP_W'(ALU_ADD);
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          mem_size = mem_size_of(op_q);
        end
        S_MEMWB: begin
          reg_dst       = 1'b0;
          mem_to_reg    = 1'b1;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWR: begin
          mem_write     = 1'b1;
          iord          = 1'b1;
          mem_size      = mem_size_of(op_q);
          instr_retired = ready;
        end
        S_EXEC:  alu_src_a = 1'b1;
        S_RWB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          ext_zero  = op_q inside {OP_ANDI, OP_ORI};
          alu_op    = (op_q inside {OP_ADDI, OP_ADDIU}) ? ALUOP_W'(ALU_ADD) : ALUOP_W'(op_q);
        end
        S_IWB: begin
          reg_dst       = 1'b0;
          reg_write     = 1'b1;
          instr_retired = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALUOP_W'(ALU_SUB);
          pc_source     = 2'b01;
          pc_write_cond = (op_q == OP_BEQ) ? 2'b01 : 2'b10;
          instr_retired = 1'b1;
        end
        S_JUMP: begin
          pc_source     = 2'b10;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a bounded memory-wait counter that escalates to a sticky bus error.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 6,
  parameter int MEM_WAIT_EN = 1,
  parameter int MAX_WAIT    = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic [1:0]         pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic [2:0]         mem_size,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_zero,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_retired,
  output logic               illegal_op,
  output logic               bus_error,
  output logic [3:0]         state_o
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t           state;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready;
  logic             stall;

  assign ready   = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign stall   = (state inside {S_FETCH, S_MEMRD, S_MEMWR}) && !ready;
  assign state_o = state;

  // NOTE: all FSM state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_FETCH;
      op_q      <= '0;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else if (stall && wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
      state     <= S_ERROR;
      wait_cnt  <= '0;
      bus_error <= 1'b1;
    end else begin
      // Counter only runs while held in a stalled memory state; any move clears it.
      wait_cnt <= stall ? wait_cnt + CNT_W'(1) : '0;
      case (state)
        S_FETCH:  if (ready) state <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          if (is_load(opcode) || is_store(opcode)) state <= S_MEMADR;
          else if (opcode == OP_RTYPE)             state <= S_EXEC;
          else if (opcode inside {OP_BEQ, OP_BNE}) state <= S_BRANCH;
          else if (opcode == OP_J)                 state <= S_JUMP;
          else if (is_imm(opcode))                 state <= S_IEXEC;
          else                                     state <= S_FETCH;
        end
        S_MEMADR: state <= is_store(op_q) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (ready) state <= S_MEMWB;
        S_MEMWR:  if (ready) state <= S_FETCH;
        S_EXEC:   state <= S_RWB;
        S_IEXEC:  state <= S_IWB;
        S_ERROR:  state <= S_ERROR;
        default:  state <= S_FETCH;
      endcase
    end
  end

  mips_mc_out_decode #(.ALUOP_W(ALUOP_W)) u_out_decode (
    .nrst          (nrst),
    .state         (state),
    .op_q          (op_q),
    .opcode        (opcode),
    .ready         (ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_size      (mem_size),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ext_zero      (ext_zero),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_retired (instr_retired),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control unit: inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, ext_zero, instr_retired, illegal_op, bus_error;
  logic [1:0] pc_write_cond, alu_src_b, pc_source;
  logic [2:0] mem_size;
  logic [5:0] alu_op;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  mips_multicycle_control #(.ALUOP_W(6), .MEM_WAIT_EN(1), .MAX_WAIT(4)) dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .pc_source(pc_source),
    .instr_retired(instr_retired), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    nrst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; mem_ready = 1'b0; opcode = 6'b0;
    #1;
    checks++;
    if ({pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write,
         mem_to_reg, instr_retired, illegal_op} !== 11'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0", {pc_write, pc_write_cond, iord,
        mem_read, mem_write, ir_write, reg_write, mem_to_reg, instr_retired, illegal_op});
    end
    checks++;
    if ({alu_op, mem_size, reg_dst} !== {6'd2, 3'b010, 1'b1}) begin
      failures++; $display("FAIL reset_idle_sel got=%b exp=%b", {alu_op, mem_size, reg_dst},
        {6'd2, 3'b010, 1'b1});
    end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1; #1;
    checks++;
    if ({state_o, bus_error} !== 5'b0) begin
      failures++; $display("FAIL reset_state got=%b exp=0", {state_o, bus_error});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    opcode = 6'b101011;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++;
    if ({state_o, mem_write, iord, instr_retired} !== {4'd5, 3'b110}) begin
      failures++; $display("FAIL memwr_wait got=%b exp=%b", {state_o, mem_write, iord, instr_retired},
        {4'd5, 3'b110});
    end
    @(negedge clk);
    nrst = 1'b0; #1;
    checks++;
    if ({mem_write, mem_read, iord, reg_write} !== 4'b0) begin
      failures++; $display("FAIL rst_drop_strobes got=%b exp=0", {mem_write, mem_read, iord, reg_write});
    end
    @(negedge clk); #1;
    checks++;
    if (mem_write !== 1'b0) begin
      failures++; $display("FAIL rst_hold_write got=%b exp=0", mem_write);
    end
    @(negedge clk);
    nrst = 1'b1; mem_ready = 1'b1; #1;
    checks++;
    if ({state_o, bus_error, mem_write} !== 6'b0) begin
      failures++; $display("FAIL rst_release got=%b exp=0", {state_o, bus_error, mem_write});
    end
  endtask

  task automatic test_store_retire();
    do_reset();
    opcode = 6'b101001;  // SH
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state_o, mem_write, mem_size, instr_retired} !== {4'd5, 1'b1, 3'b001, 1'b1}) begin
      failures++; $display("FAIL sh_retire got=%b exp=%b", {state_o, mem_write, mem_size, instr_retired},
        {4'd5, 1'b1, 3'b001, 1'b1});
    end
    @(negedge clk); #1;
    checks++;
    if (state_o !== 4'd0) begin
      failures++; $display("FAIL sh_to_fetch got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [5];
    int ret;
    exp_s = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ret = 0;
    do_reset();
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== exp_s[i]) begin
        failures++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, state_o, exp_s[i]);
      end
      if (i == 3) begin
        checks++;
        if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
          failures++; $display("FAIL rtype_rwb got=%b exp=110", {reg_write, reg_dst, mem_to_reg});
        end
      end
      ret += int'(instr_retired);
      @(negedge clk);
    end
    checks++;
    if (ret != 1) begin
      failures++; $display("FAIL rtype_retire_count got=%0d exp=1", ret);
    end
  endtask

  task automatic test_lw_stall();
    do_reset();
    opcode = 6'b100011;
    @(negedge clk); @(negedge clk); @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); #1;
      checks++;
      if ({state_o, mem_read, iord, mem_size} !== {4'd3, 2'b11, 3'b010}) begin
        failures++; $display("FAIL lw_memrd[%0d] got=%b exp=%b", k, {state_o, mem_read, iord, mem_size},
          {4'd3, 2'b11, 3'b010});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, mem_to_reg, reg_write, reg_dst, instr_retired, bus_error} !== {4'd4, 5'b11010}) begin
      failures++; $display("FAIL lw_memwb got=%b exp=%b",
        {state_o, mem_to_reg, reg_write, reg_dst, instr_retired, bus_error}, {4'd4, 5'b11010});
    end
    @(negedge clk); #1;
    checks++;
    if (state_o !== 4'd0) begin
      failures++; $display("FAIL lw_to_fetch got=%0d exp=0", state_o);
    end
  endtask

  task automatic test_lbu();
    do_reset();
    opcode = 6'b100100;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state_o, mem_size} !== {4'd3, 3'b100}) begin
      failures++; $display("FAIL lbu_size got=%b exp=%b", {state_o, mem_size}, {4'd3, 3'b100});
    end
  endtask

  task automatic test_bne();
    do_reset();
    opcode = 6'b000101;
    @(negedge clk); #1;
    checks++;
    if ({state_o, alu_src_b, alu_op} !== {4'd1, 2'b11, 6'd0}) begin
      failures++; $display("FAIL bne_decode got=%b exp=%b", {state_o, alu_src_b, alu_op},
        {4'd1, 2'b11, 6'd0});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, pc_write_cond, alu_op, pc_source, instr_retired} !==
        {4'd10, 2'b10, 6'd1, 2'b01, 1'b1}) begin
      failures++; $display("FAIL bne_branch got=%b exp=%b",
        {state_o, pc_write_cond, alu_op, pc_source, instr_retired}, {4'd10, 2'b10, 6'd1, 2'b01, 1'b1});
    end
  endtask

  task automatic test_andi();
    do_reset();
    opcode = 6'b001100;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state_o, ext_zero, alu_op, alu_src_b} !== {4'd8, 1'b1, 6'b001100, 2'b10}) begin
      failures++; $display("FAIL andi_iexec got=%b exp=%b", {state_o, ext_zero, alu_op, alu_src_b},
        {4'd8, 1'b1, 6'b001100, 2'b10});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, reg_write, reg_dst, instr_retired} !== {4'd9, 3'b101}) begin
      failures++; $display("FAIL andi_iwb got=%b exp=%b", {state_o, reg_write, reg_dst, instr_retired},
        {4'd9, 3'b101});
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = 6'b111111;
    @(negedge clk); #1;
    checks++;
    if ({state_o, illegal_op, reg_write, instr_retired} !== {4'd1, 3'b100}) begin
      failures++; $display("FAIL illegal_pulse got=%b exp=%b", {state_o, illegal_op, reg_write,
        instr_retired}, {4'd1, 3'b100});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, illegal_op, instr_retired} !== {4'd0, 2'b00}) begin
      failures++; $display("FAIL illegal_nop got=%b exp=%b", {state_o, illegal_op, instr_retired},
        {4'd0, 2'b00});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = 6'b000000;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({state_o, bus_error} !== 5'b0) begin
        failures++; $display("FAIL timeout_stall[%0d] got=%b exp=0", k, {state_o, bus_error});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, bus_error, mem_read} !== {4'd12, 2'b10}) begin
      failures++; $display("FAIL timeout_error got=%b exp=%b", {state_o, bus_error, mem_read},
        {4'd12, 2'b10});
    end
    mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({state_o, bus_error, ir_write} !== {4'd12, 2'b10}) begin
      failures++; $display("FAIL error_sticky got=%b exp=%b", {state_o, bus_error, ir_write},
        {4'd12, 2'b10});
    end
  endtask

  task automatic test_ready_last();
    do_reset();
    opcode = 6'b000000;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3); #1;
      checks++;
      if ({state_o, ir_write} !== {4'd0, (k == 3)}) begin
        failures++; $display("FAIL ready_last_fetch[%0d] got=%b exp=%b", k, {state_o, ir_write},
          {4'd0, (k == 3)});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, bus_error} !== {4'd1, 1'b0}) begin
      failures++; $display("FAIL ready_last_decode got=%b exp=%b", {state_o, bus_error}, {4'd1, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_write();
    test_store_retire();
    test_rtype();
    test_lw_stall();
    test_lbu();
    test_bne();
    test_andi();
    test_illegal();
    test_timeout();
    test_ready_last();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle MIPS control unit that replaces the single-cycle opcode decoder. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction. It adds a memory ready/wait handshake with a timeout, plus retire, illegal-opcode and bus-error status. It sits between the IR opcode field and the shared datapath (PC, IR, register file, ALU, unified memory).

Parameters:
ALUOP_W, 6, width of alu_op
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1 and wait counter disabled
MAX_WAIT, 16, max consecutive stalled cycles in a memory state before ERROR (≥1)

Ports:
clk  in  1  clock, rising edge
nrst  in  1  reset, synchronous, active-low
opcode  in  6  IR[31:26]
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  2  01 = load PC if ALU zero (BEQ), 10 = load PC if not zero (BNE), 00 = none
iord  out  1  0 = memory address from PC, 1 = from ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_size  out  3  {unsigned, size}: size 00 byte, 01 half, 10 word
ir_write  out  1  IR load
reg_dst  out  1  1 = rd, 0 = rt
mem_to_reg  out  1  1 = MDR, 0 = ALUOut
reg_write  out  1  register-file write
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 sext imm<<2
ext_zero  out  1  1 = zero-extend imm (ANDI, ORI)
alu_op  out  ALUOP_W  0 add, 1 sub/compare, 2 R-type (funct), else the I-type opcode (ORI, ANDI, SLTI, SLTIU, LUI)
pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
instr_retired  out  1  1-cycle pulse when an instruction completes
illegal_op  out  1  1-cycle pulse on unsupported opcode
bus_error  out  1  sticky memory timeout flag
state_o  out  4  current state, for debug and verification

Behaviour:
- States (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, IEXEC 8, IWB 9, BRANCH 10, JUMP 11, ERROR 12.
- Reset: when nrst=0 at a clock edge, the block loads state=FETCH, op_q=0, wait_cnt=0, bus_error=0.
- While nrst=0, outputs are forced to idle combinationally: all strobes 0, pc_write_cond=00, alu_op=2, reg_dst=1, mem_to_reg=0, mem_size=010, other selects 0.
- Outputs are a function of state and op_q only, except the ready-qualified strobes noted below. Default in every state: idle values as above.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0, pc_source=00.
  - ir_write and pc_write are 1 only when ready=1.
  - ready=1 → DECODE; else stay.
- DECODE: latch op_q<=opcode. alu_src_a=0, alu_src_b=11, alu_op=0 (branch target).
  - Next state by opcode:
    - LW/LH/LHU/LB/LBU/SW/SH/SB → MEMADR
    - R-type 000000 → EXEC
    - BEQ/BNE → BRANCH
    - J → JUMP
    - ADDI/ADDIU/ANDI/ORI/SLTI/SLTIU/LUI → IEXEC
    - any other → FETCH with illegal_op=1 for this cycle (executes as NOP, no retire pulse)
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=0. Loads → MEMRD; stores → MEMWR.
- MEMRD: mem_read=1, iord=1, mem_size from op_q. ready → MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 → FETCH.
- MEMWR: mem_write=1, iord=1, mem_size from op_q. ready → FETCH. Strobes are held steady until ready.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=2 → RWB.
- RWB: reg_dst=1, reg_write=1 → FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10.
  - ext_zero=1 for ANDI/ORI.
  - alu_op=0 for ADDI/ADDIU, else alu_op=op_q.
  - → IWB.
- IWB: reg_dst=0, reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=1, pc_source=01, pc_write_cond=01 (BEQ) or 10 (BNE) → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- Retire: instr_retired=1 in the last cycle of MEMWB, MEMWR (when ready), RWB, IWB, BRANCH and JUMP.
- Wait counter:
  - In FETCH/MEMRD/MEMWR with ready=0, wait_cnt increments.
  - If ready=0 and wait_cnt==MAX_WAIT-1 → ERROR.
  - ready=1 on the same edge wins (no error).
  - wait_cnt clears on any state change.
- ERROR: all strobes 0, bus_error=1. Stays in ERROR until reset.
- Reset mid-access drops all strobes immediately. No partial writeback is permitted.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - ALU-op codes (ADD 0, SUB 1, RTYPE 2)
  - state encodings
  - mem_size encodings
- The combinational output decode is one natural sub-module, mips_mc_out_decode (state, op_q → outputs). The FSM, wait counter and flags stay in the top module.

Test Plan:
- Reset held 2 cycles mid-MEMWR (mem_write=1) → strobes 0 during nrst=0; state_o=0 and bus_error=0 after release.
- ready tied 1, opcode 000000 → states 0,1,6,7,0; reg_write=1 and reg_dst=1 in state 7; instr_retired once.
- LW 100011 with ready low 3 cycles in MEMRD → MEMRD held 4 cycles, then MEMWB with mem_to_reg=1; mem_size=010. LBU 100100 → mem_size=100.
- BNE 000101 → BRANCH with pc_write_cond=10 and alu_op=1. ANDI 001100 → IEXEC with ext_zero=1 and alu_op=001100.
- Opcode 111111 → DECODE→FETCH, illegal_op pulse, no reg_write and no retire.
- MAX_WAIT=4, ready=0 in FETCH → ERROR after 4 stalled cycles with bus_error=1 sticky. Ready asserted on the 4th cycle instead → DECODE, no error.
